// File: rtl/map_row_fetch_pkg.sv
//------------------------------------------------------------------------------
// map_pkg
// Shared types and constants for the map row prefetcher.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package map_pkg;

    typedef enum logic [1:0] {
        GRASS  = 2'd0,
        ROAD   = 2'd1,
        FLOWER = 2'd2,
        BLACK  = 2'd3
    } map_value_t;

    localparam int MAP_ADDR_W = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/map_row_fetch_if.sv
//------------------------------------------------------------------------------
// map_row_fetch_if
// Map BRAM read bus: address out, data back one cycle later.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface map_row_fetch_if;
    import map_pkg::*;

    logic [MAP_ADDR_W-1:0] map_addr;
    logic [1:0]            map_data;

    modport master (output map_addr, input  map_data);
    modport slave  (input  map_addr, output map_data);
endinterface

`default_nettype wire

// File: rtl/map_row_fetch_line_buffer.sv
//------------------------------------------------------------------------------
// map_line_buffer
// One map row of 2-bit cells: synchronous write, registered read, async clear.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module map_line_buffer #(
    parameter int DEPTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             wr_en_i,
    input  wire logic [IDX_W-1:0] wr_idx_i,
    input  wire logic [1:0]       wr_data_i,
    input  wire logic [IDX_W-1:0] rd_idx_i,
    output logic      [1:0]       rd_data_o
);

    logic [1:0] mem_q [DEPTH];
    logic [1:0] rd_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= 2'd0;
        end else begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/map_row_fetch.sv
//------------------------------------------------------------------------------
// map_row_fetch
// Prefetches one map row per hblank into a line buffer and looks up the map
// value for each active pixel. Optional: MAP_FETCH_BOUNDS_EN (out-of-map -> black).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module map_row_fetch
    import map_pkg::*;
#(
    parameter int MAP_COLS   = 128,
    parameter int MAP_ROWS   = 128,
    parameter int CELL_SHIFT = 3,
    parameter int H_ACTIVE   = 1024,
    parameter int V_ACTIVE   = 768,
    parameter int V_TOTAL    = 806
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic [11:0]   pixel_row,
    input  wire logic [11:0]   pixel_column,
    input  wire logic          video_on,
    map_row_fetch_if.master    bram,
    output logic      [1:0]    map_value,
    output logic      [11:0]   pixel_row_o,
    output logic      [11:0]   pixel_column_o,
    output logic               video_on_o,
    output logic               fetch_busy,
    output logic               fetch_overrun
);

    localparam int COL_W = $clog2(MAP_COLS);
    localparam int ROW_W = $clog2(MAP_ROWS);

    fetch_state_t            state_q, state_d;
    logic [COL_W-1:0]        col_q;
    logic [11:0]             cell_q;
    logic [11:0]             tag_q;
    logic                    tag_valid_q;
    logic [MAP_ADDR_W-1:0]   addr_hold_q;
    logic                    oob_q;
    logic                    overrun_q;
    logic [11:0]             pixel_row_q, pixel_column_q;
    logic                    video_on_q;

    logic [11:0]             w_next_row, w_next_cell, w_col_cell;
    logic [MAP_ADDR_W-1:0]   w_fetch_addr;
    logic                    w_cell_oob, w_pix_oob, w_skip, w_trigger;
    logic                    w_start, w_wr_en;
    logic [1:0]              w_rd_data;
    logic                    w_unused_col;

    assign w_next_row   = (pixel_row == 12'(V_TOTAL - 1)) ? 12'd0 : pixel_row + 12'd1;
    assign w_next_cell  = w_next_row >> CELL_SHIFT;
    assign w_col_cell   = pixel_column >> CELL_SHIFT;
    assign w_unused_col = ^w_col_cell;
    assign w_fetch_addr = MAP_ADDR_W'({cell_q[ROW_W-1:0], col_q});

`ifdef MAP_FETCH_BOUNDS_EN
    assign w_cell_oob = (w_next_cell >= 12'(MAP_ROWS));
    assign w_pix_oob  = (w_col_cell >= 12'(MAP_COLS)) ||
                        ((pixel_row >> CELL_SHIFT) >= 12'(MAP_ROWS));
`else
    assign w_cell_oob = 1'b0;
    assign w_pix_oob  = 1'b0;
`endif

    // A cell row already resident in the buffer needs no refetch
    assign w_skip    = (w_next_row >= 12'(V_ACTIVE)) || w_cell_oob ||
                       (tag_valid_q && (tag_q == w_next_cell));
    assign w_trigger = (pixel_column == 12'(H_ACTIVE)) && !w_skip;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_start = 1'b0;
        w_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_trigger) begin
                    state_d = FETCH;
                    w_start = 1'b1;
                end
            end
            FETCH: begin
                w_wr_en = (col_q != '0);
                if (col_q == COL_W'(MAP_COLS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                w_wr_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q       <= '0;
            cell_q      <= 12'd0;
            tag_q       <= 12'd0;
            tag_valid_q <= 1'b0;
            addr_hold_q <= '0;
        end else begin
            if (w_start) begin
                cell_q <= w_next_cell;
                col_q  <= '0;
            end
            if (state_q == FETCH) begin
                col_q       <= col_q + COL_W'(1);
                addr_hold_q <= w_fetch_addr;
            end
            if (state_q == DRAIN) begin
                tag_q       <= cell_q;
                tag_valid_q <= 1'b1;
            end
        end
    end

    assign bram.map_addr = (state_q == FETCH) ? w_fetch_addr : addr_hold_q;
    assign fetch_busy    = (state_q != IDLE);

    // Data returns one cycle after its address, so it lands one entry behind col
    map_line_buffer #(
        .DEPTH (MAP_COLS),
        .IDX_W (COL_W)
    ) u_line_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (w_wr_en),
        .wr_idx_i  (col_q - COL_W'(1)),
        .wr_data_i (bram.map_data),
        .rd_idx_i  (w_col_cell[COL_W-1:0]),
        .rd_data_o (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oob_q          <= 1'b0;
            overrun_q      <= 1'b0;
            pixel_row_q    <= 12'd0;
            pixel_column_q <= 12'd0;
            video_on_q     <= 1'b0;
        end else begin
            oob_q          <= w_pix_oob;
            overrun_q      <= overrun_q | (video_on & fetch_busy);
            pixel_row_q    <= pixel_row;
            pixel_column_q <= pixel_column;
            video_on_q     <= video_on;
        end
    end

    assign map_value      = oob_q ? 2'(BLACK) : w_rd_data;
    assign pixel_row_o    = pixel_row_q;
    assign pixel_column_o = pixel_column_q;
    assign video_on_o     = video_on_q;
    assign fetch_overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_map_row_fetch.sv
//------------------------------------------------------------------------------
// tb_map_row_fetch
// Directed self-checking bench for map_row_fetch (default build).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_map_row_fetch;

    logic        clk;
    logic        reset_n;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic        video_on;
    logic [1:0]  map_value;
    logic [11:0] pixel_row_o;
    logic [11:0] pixel_column_o;
    logic        video_on_o;
    logic        fetch_busy;
    logic        fetch_overrun;

    int checks   = 0;
    int failures = 0;

    map_row_fetch_if bram_if ();

    map_row_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pixel_row      (pixel_row),
        .pixel_column   (pixel_column),
        .video_on       (video_on),
        .bram           (bram_if.master),
        .map_value      (map_value),
        .pixel_row_o    (pixel_row_o),
        .pixel_column_o (pixel_column_o),
        .video_on_o     (video_on_o),
        .fetch_busy     (fetch_busy),
        .fetch_overrun  (fetch_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency, data = addr[1:0]
    always @(posedge clk) bram_if.map_data <= bram_if.map_addr[1:0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after the trigger edge: verifies the 128-address burst and busy time
    task automatic fetch_seq(input string tag, input int base);
        int bad;
        int busy_cnt;
        bad      = 0;
        busy_cnt = 0;
        for (int k = 0; k < 128; k++) begin
            if (bram_if.map_addr !== 14'(base + k)) bad++;
            if (fetch_busy === 1'b1) busy_cnt++;
            step();
        end
        if (fetch_busy === 1'b1) busy_cnt++;
        step();
        chk({tag, "_addr_errs"}, bad, 0);
        chk({tag, "_busy_cycles"}, busy_cnt, 129);
        chk({tag, "_idle"}, {31'd0, fetch_busy}, 0);
        chk({tag, "_addr_hold"}, {18'd0, bram_if.map_addr}, base + 127);
    endtask

    task automatic lookup(input string tag, input int row, input int col, input int exp);
        pixel_row    = 12'(row);
        pixel_column = 12'(col);
        video_on     = 1'b1;
        step();
        chk({tag, "_value"}, {30'd0, map_value}, exp);
        chk({tag, "_col_o"}, {20'd0, pixel_column_o}, col);
        video_on     = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        pixel_row    = 12'd0;
        pixel_column = 12'd0;
        video_on     = 1'b0;
        step();
        step();
        chk("rst_map_value", {30'd0, map_value}, 0);
        chk("rst_map_addr", {18'd0, bram_if.map_addr}, 0);
        chk("rst_busy", {31'd0, fetch_busy}, 0);
        chk("rst_overrun", {31'd0, fetch_overrun}, 0);
        chk("rst_row_o", {20'd0, pixel_row_o}, 0);
        reset_n = 1'b1;
        step();

        // Row wrap: trigger on last frame line fetches cell row 0
        pixel_row    = 12'd805;
        pixel_column = 12'd1024;
        step();
        pixel_column = 12'd1025;
        fetch_seq("fetch0", 16'h0000);

        lookup("lk17", 0, 17, 2);
        chk("lk17_row_o", {20'd0, pixel_row_o}, 0);
        chk("lk17_von_o", {31'd0, video_on_o}, 1);
        lookup("lk8", 0, 8, 1);
        lookup("lk1023", 0, 1023, 3);
        lookup("lk600", 0, 600, 3);
        lookup("lk0", 0, 0, 0);
        chk("no_overrun", {31'd0, fetch_overrun}, 0);

        // Same cell row already resident: no fetch
        pixel_row    = 12'd0;
        pixel_column = 12'd1024;
        step();
        chk("skip_busy", {31'd0, fetch_busy}, 0);
        chk("skip_addr", {18'd0, bram_if.map_addr}, 16'h007F);
        pixel_column = 12'd1025;
        step();
        chk("skip_busy2", {31'd0, fetch_busy}, 0);

        pixel_row    = 12'd7;
        pixel_column = 12'd1024;
        step();
        pixel_column = 12'd1025;
        fetch_seq("fetch1", 16'h0080);

        // Vblank: next row 768 is outside active video
        pixel_row    = 12'd767;
        pixel_column = 12'd1024;
        step();
        chk("vblank_busy", {31'd0, fetch_busy}, 0);
        chk("vblank_addr", {18'd0, bram_if.map_addr}, 16'h00FF);
        pixel_column = 12'd1025;
        step();

        // Overrun: video_on during a fetch
        pixel_row    = 12'd15;
        pixel_column = 12'd1024;
        step();
        pixel_column = 12'd1025;
        for (int i = 0; i < 50; i++) step();
        video_on = 1'b1;
        step();
        video_on = 1'b0;
        step();
        chk("overrun_set", {31'd0, fetch_overrun}, 1);
        for (int i = 0; i < 200 && fetch_busy; i++) step();
        chk("overrun_done_busy", {31'd0, fetch_busy}, 0);
        chk("overrun_sticky", {31'd0, fetch_overrun}, 1);
        lookup("lk_row2", 16, 17, 2);

        // Reset mid-fetch
        pixel_row    = 12'd23;
        pixel_column = 12'd1024;
        step();
        pixel_column = 12'd1025;
        for (int i = 0; i < 60; i++) step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, fetch_busy}, 0);
        chk("mid_rst_addr", {18'd0, bram_if.map_addr}, 0);
        chk("mid_rst_overrun", {31'd0, fetch_overrun}, 0);
        chk("mid_rst_row_o", {20'd0, pixel_row_o}, 0);
        chk("mid_rst_col_o", {20'd0, pixel_column_o}, 0);
        chk("mid_rst_value", {30'd0, map_value}, 0);
        step();
        reset_n = 1'b1;
        lookup("lk_cleared", 24, 17, 0);

        pixel_row    = 12'd23;
        pixel_column = 12'd1024;
        step();
        pixel_column = 12'd1025;
        fetch_seq("refetch", 16'h0180);
        lookup("lk_refetch", 24, 17, 2);
        lookup("lk_refetch_b", 24, 1019, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
